// File: rtl/prog_loader_if.sv
// Host byte stream in, program-memory write port and loader status out.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            mem_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_data, mem_addr, mem_we, cpu_hold, busy, done, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_data, mem_addr, mem_we, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte stream -> program memory writes, with CPU hold and per-record checksum.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         clr,
  prog_loader_if.slave bus
);
  localparam logic [7:0] SYNC = 8'h55;
  localparam logic [7:0] ENDB = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_WRITE, S_CHK
  } state_t;

  state_t                state;
  logic [7:0]            acc;
  logic [7:0]            addr_hi;
  logic [8:0]            cnt;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  accept;
  logic [7:0]            acc_next;

  if (ADDR_WIDTH < 9 || ADDR_WIDTH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("prog_loader: ADDR_WIDTH must be 9..16 and TIMEOUT_CYCLES >= 1");
  end

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign acc_next = acc + bus.rx_data;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
`endif

  // waddr tracks the next write address; mem_addr only moves when a byte is written
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= S_IDLE;
      acc          <= '0;
      addr_hi      <= '0;
      cnt          <= '0;
      waddr        <= '0;
      bus.rx_ready <= 1'b1;
      bus.mem_data <= '0;
      bus.mem_addr <= '0;
      bus.mem_we   <= 1'b0;
      bus.cpu_hold <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (bus.rx_data == SYNC) begin
            state        <= S_ADDR_H;
            acc          <= '0;
            bus.cpu_hold <= 1'b1;
            bus.busy     <= 1'b1;
          end else if (bus.rx_data == ENDB && !bus.error) begin
            bus.cpu_hold <= 1'b0;
            bus.done     <= 1'b1;
          end
        end
        S_ADDR_H: if (accept) begin
          addr_hi <= bus.rx_data;
          acc     <= acc_next;
          state   <= S_ADDR_L;
        end
        S_ADDR_L: if (accept) begin
          waddr <= ADDR_WIDTH'({addr_hi, bus.rx_data});
          acc   <= acc_next;
          state <= S_LEN;
        end
        S_LEN: if (accept) begin
          cnt   <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          acc   <= acc_next;
          state <= S_DATA;
        end
        S_DATA: if (accept) begin
          bus.mem_data <= bus.rx_data;
          bus.mem_addr <= waddr;
          bus.mem_we   <= 1'b1;
          bus.rx_ready <= 1'b0;
          acc          <= acc_next;
          state        <= S_WRITE;
        end
        S_WRITE: begin
          waddr        <= waddr + ADDR_WIDTH'(1);
          cnt          <= cnt - 9'd1;
          bus.rx_ready <= 1'b1;
          state        <= (cnt == 9'd1) ? S_CHK : S_DATA;
        end
        S_CHK: if (accept) begin
          if (acc_next != 8'h00) bus.error <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          bus.busy     <= 1'b0;
          bus.rx_ready <= 1'b1;
        end
      endcase
`ifdef LOADER_TIMEOUT_EN
      // abort overrides the case above; cpu_hold is left set
      if (accept || state == S_IDLE) begin
        idle_cnt <= '0;
      end else if (state != S_WRITE) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state        <= S_IDLE;
          bus.busy     <= 1'b0;
          bus.error    <= 1'b1;
          bus.rx_ready <= 1'b1;
          idle_cnt     <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
`endif
    end
  end
endmodule
